// File: rtl/consumer_fwft.sv
// Read-side FWFT stage of an async FIFO: prefetches one word from the RAM into
// a holding register and tracks read pointers and occupancy flags. Optional
// underflow tracking is built when CONSUMER_UNDERFLOW_EN is defined.
module consumer_fwft #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  r_rst,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH:0]   gray_wptrsync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH:0]   binary_rptr,
  output logic [ADDR_WIDTH:0]   gray_rptr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [7:0]            underflow_cnt
);

  localparam int PW = ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         bptr_q, bptr_d;
  logic [PW-1:0]         gptr_q, gptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ae_q, ae_d;
  logic                  fetch;
  logic                  mem_empty;
  logic [PW-1:0]         wbin;
  logic [PW-1:0]         occ;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Gray compare stays exact across pointer wrap since both sides wrap alike.
  assign mem_empty = (gptr_q == gray_wptrsync);
  assign wbin      = gray2bin(gray_wptrsync);
  assign occ       = wbin - bptr_q + {{(PW-1){1'b0}}, (state_q != S_IDLE)};
  assign ae_d      = (occ <= PW'(AE_LEVEL));

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    fetch   = 1'b0;
    case (state_q)
      S_IDLE: if (!mem_empty) begin
        fetch   = 1'b1;
        state_d = S_PEND;
      end
      S_PEND: begin
        rdata_d = mem_rdata;
        state_d = S_HOLD;
      end
      S_HOLD: if (r_en) begin
        if (!mem_empty) begin
          fetch   = 1'b1;
          state_d = S_PEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bptr_d = bptr_q;
    gptr_d = gptr_q;
    if (fetch) begin
      bptr_d = bptr_q + 1'b1;
      gptr_d = bptr_d ^ (bptr_d >> 1);
    end
  end

  always_ff @(posedge clk or posedge r_rst) begin
    if (r_rst) begin
      state_q <= S_IDLE;
      bptr_q  <= '0;
      gptr_q  <= '0;
      rdata_q <= '0;
      ae_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bptr_q  <= bptr_d;
      gptr_q  <= gptr_d;
      rdata_q <= rdata_d;
      ae_q    <= ae_d;
    end
  end

  // Reset gates the strobe so no read issues while pointers are being cleared.
  assign mem_ren      = fetch & ~r_rst;
  assign mem_raddr    = bptr_q[ADDR_WIDTH-1:0];
  assign binary_rptr  = bptr_q;
  assign gray_rptr    = gptr_q;
  assign rdata        = rdata_q;
  assign rvalid       = (state_q == S_HOLD);
  assign empty        = ~rvalid;
  assign almost_empty = ae_q;

`ifdef CONSUMER_UNDERFLOW_EN
  logic       uf_q, uf_d;
  logic [7:0] ucnt_q, ucnt_d;

  always_comb begin
    uf_d   = r_en & ~rvalid;
    ucnt_d = ucnt_q;
    if (uf_d && ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge r_rst) begin
    if (r_rst) begin
      uf_q   <= 1'b0;
      ucnt_q <= '0;
    end else begin
      uf_q   <= uf_d;
      ucnt_q <= ucnt_d;
    end
  end

  assign underflow     = uf_q;
  assign underflow_cnt = ucnt_q;
`else
  assign underflow     = 1'b0;
  assign underflow_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_consumer_fwft.sv
// Randomized bench for consumer_fwft: the bench owns the RAM and a
// word-level model of the prefetch/hold behaviour.
module tb_consumer_fwft;

  logic       clk = 1'b0;
  logic       r_rst;
  logic       r_en;
  logic [9:0] gray_wptrsync;
  logic [7:0] mem_rdata;
  logic       mem_ren;
  logic [8:0] mem_raddr;
  logic [9:0] binary_rptr;
  logic [9:0] gray_rptr;
  logic [7:0] rdata;
  logic       rvalid;
  logic       empty;
  logic       almost_empty;
  logic       underflow;
  logic [7:0] underflow_cnt;

  consumer_fwft #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .AE_LEVEL(4)) dut (
    .clk(clk), .r_rst(r_rst), .r_en(r_en), .gray_wptrsync(gray_wptrsync),
    .mem_rdata(mem_rdata), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .binary_rptr(binary_rptr), .gray_rptr(gray_rptr), .rdata(rdata),
    .rvalid(rvalid), .empty(empty), .almost_empty(almost_empty),
    .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [512];
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

  int n_tests = 0;
  int n_fail  = 0;

  // Word-level model: counts of words written/fetched, plus whether a word is
  // in flight from the RAM or sitting in the output register.
  int         m_wp, m_rp, m_faddr, m_cnt, wraps;
  bit         m_valid, m_pend, m_ae, m_uf;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] to_gray(input int b);
    logic [9:0] v;
    v = b[9:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int used();
    return (m_wp - m_rp) & 1023;
  endfunction

  task automatic push();
    mem[m_wp % 512] = 8'($urandom);
    m_wp = (m_wp + 1) % 1024;
    gray_wptrsync = to_gray(m_wp);
  endtask

  task automatic model_reset();
    m_rp = 0; m_valid = 0; m_pend = 0; m_data = '0;
    m_ae = 1; m_uf = 0; m_cnt = 0;
  endtask

  task automatic check_regs();
    chk("rvalid", rvalid, m_valid);
    chk("empty", empty, !m_valid);
    chk("rdata", rdata, m_data);
    chk("binary_rptr", binary_rptr, m_rp);
    chk("gray_rptr", gray_rptr, to_gray(m_rp));
    chk("almost_empty", almost_empty, m_ae);
`ifdef CONSUMER_UNDERFLOW_EN
    chk("underflow", underflow, m_uf);
    chk("underflow_cnt", underflow_cnt, m_cnt);
`else
    chk("underflow", underflow, 0);
    chk("underflow_cnt", underflow_cnt, 0);
`endif
  endtask

  // Called at a negedge with inputs applied; advances one clock.
  task automatic cyc();
    bit f;
    int occ;
    #1;
    f = (m_rp != m_wp) && ((!m_valid && !m_pend) || (m_valid && r_en));
    chk("mem_ren", mem_ren, f);
    if (f) chk("mem_raddr", mem_raddr, m_rp % 512);
    occ = used() + ((m_valid || m_pend) ? 1 : 0);
    @(posedge clk);
    m_ae = (occ <= 4);
    m_uf = r_en && !m_valid;
    if (m_uf && m_cnt < 255) m_cnt++;
    if (m_pend) begin
      m_pend  = 0;
      m_valid = 1;
      m_data  = mem[m_faddr];
    end else if (m_valid && r_en) begin
      m_valid = 0;
    end
    if (f) begin
      m_pend  = 1;
      m_faddr = m_rp % 512;
      m_rp    = (m_rp + 1) % 1024;
      if (m_rp == 0) wraps++;
    end
    @(negedge clk);
    check_regs();
  endtask

  task automatic reset_checks();
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_binary_rptr", binary_rptr, 0);
    chk("rst_gray_rptr", gray_rptr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_underflow", underflow, 0);
    chk("rst_underflow_cnt", underflow_cnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem_rdata = '0;
    r_rst = 1'b1; r_en = 1'b0; gray_wptrsync = '0;
    m_wp = 0; wraps = 0; m_faddr = 0;
    model_reset();
    #1 reset_checks();
    @(negedge clk); @(negedge clk);
    r_rst = 1'b0;

    // Idle with an empty RAM: no reads may be issued.
    for (int i = 0; i < 20; i++) cyc();

    // Single word: fetched from address 0, presented two cycles later.
    push();
    for (int i = 0; i < 4; i++) cyc();
    chk("single_valid", rvalid, 1);
    chk("single_rptr", binary_rptr, 1);

    // Three more words with continuous pop.
    r_en = 1'b1;
    push(); push(); push();
    for (int i = 0; i < 12; i++) cyc();
    chk("burst_drained", empty, 1);

    // Random traffic long enough to wrap the read pointer.
    for (int i = 0; i < 5000; i++) begin
      if (($urandom % 4) < ((i < 3000) ? 3 : 1) && used() < 500) push();
      r_en = ($urandom % 4) != 0;
      cyc();
    end
    chk("ptr_wrapped", wraps > 0, 1);

    // Drain, then pop repeatedly while empty.
    r_en = 1'b1;
    for (int i = 0; i < 1200 && !(m_rp == m_wp && !m_valid && !m_pend); i++) cyc();
    chk("drained", {m_valid, m_pend, used() == 0}, 3'b001);
    for (int i = 0; i < 300; i++) begin
      r_en = 1'b1; cyc();
      r_en = 1'b0; cyc();
    end
`ifdef CONSUMER_UNDERFLOW_EN
    chk("ucnt_saturated", underflow_cnt, 255);
`else
    chk("ucnt_tied", underflow_cnt, 0);
`endif

    // Five words buffered, then pop one: almost_empty crosses its threshold.
    r_en = 1'b0;
    for (int i = 0; i < 5; i++) push();
    for (int i = 0; i < 6; i++) cyc();
    chk("ae_occ5", almost_empty, 0);
    r_en = 1'b1; cyc();
    r_en = 1'b0; cyc();
    chk("ae_occ4", almost_empty, 1);

    // Reset while a fetch is in flight.
    r_en = 1'b1;
    for (int i = 0; i < 20 && !m_pend; i++) cyc();
    chk("reached_pend", m_pend, 1);
    r_rst = 1'b1; r_en = 1'b0;
    model_reset();
    #1 reset_checks();
    @(negedge clk);
    chk("rst_hold_rvalid", rvalid, 0);
    r_rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
